// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone block-RAM controller.
// No logic; elaboration-time only.
// No flow control of its own.
package wb_bram_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // CSR byte offsets relative to the CSR window base
  localparam logic [19:0] CSR_DELAY = 20'h00000;
  localparam logic [19:0] CSR_CNT   = 20'h00004;
  localparam logic [19:0] CSR_STAT  = 20'h00008;

  // Ceiling log2, used to size the RAM word index
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_bram_sp.sv
// Inferred single-port RAM, 32-bit words with per-byte write lanes.
// Latency: read data valid one cycle after en.
// Backpressure: none; accepts an access every enabled cycle.
module wb_bram_sp #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Byte-lane write and registered read (old data on a same-cycle write)
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave in front of a byte-enable block RAM, with a small CSR window.
// Latency: memory ack in cycle delay_reg+2, CSR ack in cycle 1 (request = cycle 0).
// Backpressure: master is held via withheld ack; one transaction in flight.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [11:0] BASE_HI       = 12'h380,
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          DELAY_W       = 8,
  parameter int          DEFAULT_DELAY = 10,
  parameter logic [19:0] CSR_BASE      = 20'hFFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);

  localparam int AW = clog2(DEPTH_WORDS);

  state_t state, state_nxt;

  logic               req, is_csr;
  logic [17:0]        csr_word;
  logic [31:0]        csr_val, csr_rdat;
  logic [DELAY_W-1:0] delay_reg, lat_delay, wcnt;
  logic [31:0]        acc_cnt;
  logic               last_we;
  logic               cap_we, cap_csr;
  logic [3:0]         cap_sel;
  logic [31:0]        cap_dat;
  logic [AW-1:0]      cap_idx;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [31:0]        ram_dout;

  assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE_HI);
  assign is_csr   = wbs_adr_i[19:0] >= CSR_BASE;
  assign csr_word = wbs_adr_i[19:2] - CSR_BASE[19:2];

  // CSR read decode; unmapped offsets read zero
  always_comb begin
    csr_val = '0;
    if (csr_word == CSR_DELAY[19:2])     csr_val = 32'(delay_reg);
    else if (csr_word == CSR_CNT[19:2])  csr_val = acc_cnt;
    else if (csr_word == CSR_STAT[19:2]) csr_val = {31'd0, last_we};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; dropping cyc only aborts before the RAM is touched
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (is_csr)                state_nxt = S_RESP;
          else if (delay_reg != '0)  state_nxt = S_WAIT;
          else                       state_nxt = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i)                                state_nxt = S_IDLE;
        else if (wcnt == lat_delay - DELAY_W'(1))      state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait counting, CSR writes and access bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_reg <= DELAY_W'(DEFAULT_DELAY);
      acc_cnt   <= '0;
      last_we   <= 1'b0;
      lat_delay <= '0;
      wcnt      <= '0;
      cap_we    <= 1'b0;
      cap_csr   <= 1'b0;
      cap_sel   <= '0;
      cap_dat   <= '0;
      cap_idx   <= '0;
      csr_rdat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_we    <= wbs_we_i;
            cap_csr   <= is_csr;
            cap_sel   <= wbs_sel_i;
            cap_dat   <= wbs_dat_i;
            cap_idx   <= wbs_adr_i[AW+1:2];
            lat_delay <= delay_reg;
            wcnt      <= '0;
            if (is_csr) begin
              last_we  <= wbs_we_i;
              csr_rdat <= csr_val;
              if (wbs_we_i && wbs_sel_i[0] && (csr_word == CSR_DELAY[19:2]))
                delay_reg <= wbs_dat_i[DELAY_W-1:0];
            end
          end
        end
        S_WAIT:   wcnt    <= wcnt + DELAY_W'(1);
        S_ACCESS: last_we <= cap_we;
        S_RESP:   if (!cap_csr) acc_cnt <= acc_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; data bus is zero except in a read response
  always_comb begin
    wbs_ack_o = (state == S_RESP);
    busy_o    = (state != S_IDLE);
    ram_en    = (state == S_ACCESS);
    ram_we    = (state == S_ACCESS && cap_we) ? cap_sel : 4'h0;
    wbs_dat_o = '0;
    if (state == S_RESP && !cap_we)
      wbs_dat_o = cap_csr ? csr_rdat : ram_dout;
  end

  wb_bram_sp #(.AW(AW)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (cap_idx),
    .din  (cap_dat),
    .dout (ram_dout)
  );

endmodule

// File: doc/wb_bram_ctrl.md
Name: wb_bram_ctrl

Overview:
- Parametrised Wishbone slave fronting a byte-enable single-port block RAM in the user project area.
- Access latency is run-time programmable: a CSR sets the number of inserted wait states, where earlier designs used a fixed elaboration-time delay.
- Also provides an access counter, cycle abort, and a decoded CSR window.
- Sits between the Wishbone slave port and the user-area firmware/data memory.

Parameters:
- BASE_HI, 12'h380: required value of wbs_adr_i[31:20] for a hit.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- DELAY_W, 8: width of the wait-state register.
- DEFAULT_DELAY, 10: reset value of the wait-state register.
- CSR_BASE, 20'hFFF00: wbs_adr_i[19:0] at or above this value selects the CSR window.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge; registered, one-cycle pulse
- wbs_dat_o  out  32  read data; registered
- busy_o  out  1  high while the FSM is not IDLE

Behaviour:
- Request handling
  - req = cyc & stb & (adr[31:20]==BASE_HI). Non-hits are ignored: no ack.
  - Word index = adr[2+AW-1:2], AW = clog2(DEPTH_WORDS). Higher offset bits below CSR_BASE are ignored, so addresses alias/wrap.
- Reset values
  - state=IDLE, ack=0, dat_o=0, busy=0.
  - delay_reg=DEFAULT_DELAY, acc_cnt=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE, req on memory address: capture adr/dat/sel/we and clear wait counter. Go to WAIT if delay_reg!=0, else ACCESS.
  - IDLE, req on CSR address: go directly to RESP. A CSR write takes effect at that edge.
  - WAIT: counter increments. Leave for ACCESS when counter==delay_reg-1, i.e. exactly delay_reg WAIT cycles. delay_reg is latched at capture; mid-transaction CSR changes cannot occur.
  - ACCESS: RAM enabled once. Write uses captured sel as byte enables; read data is valid next cycle. Go to RESP.
  - RESP: ack=1 for exactly one cycle. dat_o = RAM data (read), CSR value (CSR read), or 0 (any write). Increment acc_cnt on memory transactions only; it wraps at 2^32. Return to IDLE.
- Latency (request first visible in cycle 0)
  - Memory: ack in cycle delay_reg+2.
  - CSR: ack in cycle 1.
- Back-to-back: IDLE re-samples req the cycle after RESP. A stb still high there is a new transaction.
- Abort: cyc low while in WAIT returns to IDLE next edge, with no RAM access, no ack, no count. Once in ACCESS the transaction completes and acks regardless of cyc.
- Outside RESP, ack=0 and dat_o=0.
- CSR map (offset from CSR_BASE, word aligned)
  - 0x00 DELAY: R/W, DELAY_W bits zero-extended; byte-select honoured on byte 0 only.
  - 0x04 ACC_CNT: RO; writes acked and ignored.
  - 0x08 STATUS: bit0 = last transaction was a write.
  - Other CSR offsets read 0; writes are acked and ignored.
- Reset mid-transaction: the FSM aborts to IDLE. Any RAM write already issued in ACCESS stands.
- wbs_sel_i=0 on a write: acked, no bytes modified.

Decomposition:
- Package wb_bram_pkg holds:
  - state enum (IDLE/WAIT/ACCESS/RESP)
  - CSR offset constants (CSR_DELAY=0x00, CSR_CNT=0x04, CSR_STAT=0x08)
  - the clog2 helper
- Sub-module wb_bram_sp: single-port RAM.
  - Ports: clk, en, we[3:0], addr[AW-1:0], din, dout. One-cycle read latency, byte-lane writes.
  - Inferred, so the technology macro can be swapped without touching the controller.

Test Plan:
- Reset, then write 0xA5A5_1234 to 0x3800_0010 with sel=4'hF, then read it back. Expect each ack in cycle 12 and dat_o=0xA5A5_1234.
- Write 0 to CSR DELAY (0x380F_FF00), then a memory read. Expect the CSR ack in cycle 1, the read ack in cycle 2, and a DELAY readback of 0.
- Word 0x3800_0020 holds 0xFFFF_FFFF; write 0x0000_0000 with sel=4'b0101. Expect a readback of 0xFF00_FF00.
- DELAY=5, start a write, drop cyc in cycle 3. Expect no ack, unchanged memory contents, and ACC_CNT unchanged.
- Three back-to-back memory accesses with stb held high, then read ACC_CNT. Expect 3 acks spaced delay+3 cycles apart and ACC_CNT=3. Access 0x3900_0000: expect no ack over 20 cycles.
- Assert rst during WAIT. Expect next cycle busy_o=0, ack=0, DELAY reads 10, ACC_CNT reads 0.
